// File: rtl/nco_v3_sine_if.sv
// Frequency-word / sine-sample bundle between the NCO and its user.
// The NCO side takes the slave modport.
interface nco_v3_sine_if #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int AMPLITUDE_BITS   = 14
);
   logic        [AXIS_TDATA_WIDTH-1:0] FREQ_WORD;
   logic signed [AMPLITUDE_BITS-1:0]   WAVE;

   modport master (output FREQ_WORD, input WAVE);
   modport slave  (input FREQ_WORD, output WAVE);
endinterface

// File: rtl/nco_v3_sine.sv
// Phase-accumulator NCO with a quarter-wave sine ROM.
// Three registers sit between the accumulator and WAVE: fold, ROM read, negate.
module nco_v3_sine #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int ACCUM_WIDTH      = 32,
   parameter int PHASE_BITS       = 16,
   parameter int AMPLITUDE_BITS   = 14
) (
   input logic          clk,
   input logic          rst,
   nco_v3_sine_if.slave nco
);
   localparam int  ADDR_BITS = PHASE_BITS - 2;
   localparam int  ROM_DEPTH = 1 << ADDR_BITS;
   localparam int  MAG_BITS  = AMPLITUDE_BITS - 1;
   localparam real AMP       = real'((1 << MAG_BITS) - 1);
   localparam real PI        = 3.14159265358979323846;

   logic [ACCUM_WIDTH-1:0]    freq_ext;
   logic [ACCUM_WIDTH-1:0]    acc;
   logic [PHASE_BITS-1:0]     phase;
   logic [ADDR_BITS-1:0]      offset;
   logic [ADDR_BITS-1:0]      addr_q;
   logic                      sign_q;
   logic                      sign_d;
   logic [MAG_BITS-1:0]       mag_q;
   logic [AMPLITUDE_BITS-1:0] mag_ext;
   logic [MAG_BITS-1:0]       rom [ROM_DEPTH];

   generate
      if (AXIS_TDATA_WIDTH >= ACCUM_WIDTH) begin : g_freq_trunc
         assign freq_ext = nco.FREQ_WORD[ACCUM_WIDTH-1:0];
      end else begin : g_freq_zext
         assign freq_ext = {{(ACCUM_WIDTH-AXIS_TDATA_WIDTH){1'b0}}, nco.FREQ_WORD};
      end
   endgenerate

   // Half-sample offset keeps the table symmetric, so mirroring with ~offset is exact.
   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
      localparam real         ANGLE = 2.0 * PI * (real'(i) + 0.5) / (4.0 * real'(ROM_DEPTH));
      localparam int unsigned VAL   = $rtoi(AMP * $sin(ANGLE) + 0.5);
      assign rom[i] = MAG_BITS'(VAL);
   end

   assign phase   = acc[ACCUM_WIDTH-1 -: PHASE_BITS];
   assign offset  = phase[ADDR_BITS-1:0];
   assign mag_ext = {1'b0, mag_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         addr_q   <= '0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         sign_d   <= 1'b0;
         nco.WAVE <= '0;
      end else begin
         acc      <= acc + freq_ext;
         addr_q   <= phase[PHASE_BITS-2] ? ~offset : offset;
         sign_q   <= phase[PHASE_BITS-1];
         mag_q    <= rom[addr_q];
         sign_d   <= sign_q;
         nco.WAVE <= sign_d ? -mag_ext : mag_ext;
      end
   end
endmodule

// File: tb/tb_nco_v3_sine.sv
// Scoreboard bench for nco_v3_sine: the driver queues the expected WAVE for
// every edge, the monitor pops and compares one entry per edge.
module tb_nco_v3_sine;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;

   nco_v3_sine_if #(.AXIS_TDATA_WIDTH(32), .AMPLITUDE_BITS(14)) bus ();

   nco_v3_sine #(
      .AXIS_TDATA_WIDTH(32),
      .ACCUM_WIDTH     (32),
      .PHASE_BITS      (16),
      .AMPLITUDE_BITS  (14)
   ) dut (
      .clk(clk),
      .rst(rst),
      .nco(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    exp_val;
      int    tol;
      string tag;
   } exp_t;

   exp_t sb_q [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // acc_m: accumulator value held before the next edge; acc_d1/acc_d2: one and two edges earlier
   logic [31:0] acc_m  = '0;
   logic [31:0] acc_d1 = '0;
   logic [31:0] acc_d2 = '0;

   // Hand-computed samples at multiples of 2^28 (sixteenth of a turn)
   int tbl16 [16] = '{0, 3135, 5792, 7567, 8191, 7567, 5792, 3135,
                      0, -3135, -5792, -7567, -8191, -7567, -5792, -3135};

   localparam logic [31:0] F_008  = 32'd343597384;
   localparam logic [31:0] F_Q    = 32'h4000_0000;
   localparam logic [31:0] F_16   = 32'h1000_0000;
   localparam logic [31:0] F_8    = 32'h2000_0000;
   localparam logic [31:0] F_ALIAS = 32'hC000_0000;

   function automatic void exp_for(input logic [31:0] a, output int e, output int tol);
      if (a[27:0] == 28'd0) begin
         e   = tbl16[a[31:28]];
         tol = (a[29:28] == 2'd0) ? 0 : 1;
      end else begin
         e   = int'($floor(8191.0 * $sin(2.0 * PI * real'(a) / 4294967296.0) + 0.5));
         tol = 2;
      end
   endfunction

   task automatic step(input logic r, input logic [31:0] fw, input string tag);
      exp_t e;
      rst           = r;
      bus.FREQ_WORD = fw;
      e.tag         = tag;
      if (r) begin
         e.exp_val = 0;
         e.tol     = 0;
         acc_m     = '0;
         acc_d1    = '0;
         acc_d2    = '0;
      end else begin
         exp_for(acc_d2, e.exp_val, e.tol);
         acc_d2 = acc_d1;
         acc_d1 = acc_m;
         acc_m  = acc_m + fw;
      end
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic r, input logic [31:0] fw, input string tag);
      for (int i = 0; i < n; i++) step(r, fw, tag);
   endtask

   initial begin : monitor
      exp_t e;
      int   act;
      int   diff;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            act  = int'(bus.WAVE);
            diff = act - e.exp_val;
            if (diff < 0) diff = -diff;
            n_cmp++;
            if (diff > e.tol) begin
               n_fail++;
               $display("FAIL %s: WAVE=%0d required %0d (+/-%0d) at %0t",
                        e.tag, act, e.exp_val, e.tol, $time);
            end
         end
      end
   end

   initial begin : driver
      bus.FREQ_WORD = F_008;
      run(3,   1'b1, F_008,   "reset_hold");
      run(200, 1'b0, F_008,   "rate_008");
      run(1,   1'b1, F_008,   "mid_reset");
      run(200, 1'b0, F_008,   "restart_008");
      run(10,  1'b0, 32'd0,   "hold_008");
      run(2,   1'b1, F_Q,     "reset_q");
      run(20,  1'b0, F_Q,     "quarter");
      run(12,  1'b0, F_ALIAS, "alias");
      run(1,   1'b1, F_16,    "reset_16");
      run(41,  1'b0, F_16,    "rate_1_16");
      run(20,  1'b0, F_8,     "step_2x");
      run(10,  1'b0, 32'd0,   "hold_peak");
      run(6,   1'b0, F_16,    "resume");
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending=%0d required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
